// File: rtl/fetch_unit.sv
// Two-wide instruction fetch front end: issues paired 16-bit fetches and buffers
// the returned instructions, with their byte PCs, in a circular queue for decode.
module fetch_unit #(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [15:0]               redirect_pc,
  output logic [15:0]               im_addr_1,
  output logic [15:0]               im_addr_2,
  input  logic [15:0]               im_inst_1,
  input  logic [15:0]               im_inst_2,
  input  logic [1:0]                deq_count,
  output logic                      out_valid_1,
  output logic                      out_valid_2,
  output logic [15:0]               out_inst_1,
  output logic [15:0]               out_inst_2,
  output logic [15:0]               out_pc_1,
  output logic [15:0]               out_pc_2,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int          PW      = $clog2(QDEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [PW:0] L_QD    = (PW + 1)'(QDEPTH);
  localparam logic [CW:0] L_LIMIT = (CW + 1)'(QDEPTH - 2);

  // QDEPTH need not be a power of two, so pointer wrap is an explicit compare.
  function automatic logic [PW-1:0] f_ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    logic [PW:0] w;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    w = (s >= L_QD) ? (s - L_QD) : s;
    return w[PW-1:0];
  endfunction

  logic [15:0]   r_pc;
  logic [15:0]   r_inflight_pc;
  logic          r_inflight;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [15:0]   r_q_inst [QDEPTH];
  logic [15:0]   r_q_pc   [QDEPTH];

  logic [15:0]   w_redir_pc;
  logic [CW:0]   w_need;
  logic          w_issue;
  logic          w_push;
  logic [1:0]    w_deq;
  logic [1:0]    w_pop;
  logic [CW-1:0] w_push_amt;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_head_1;
  logic [PW-1:0] w_tail_1;
  logic          w_valid_1;
  logic          w_valid_2;

  assign w_redir_pc = redirect_pc & 16'hFFFE;

  // Reservation counts the in-flight pair as already occupying two slots.
  assign w_need  = {1'b0, r_count} + {{(CW-1){1'b0}}, r_inflight, 1'b0};
  assign w_issue = ~redirect_valid & (w_need <= L_LIMIT);
  assign w_push  = r_inflight & ~redirect_valid;

  assign w_head_1 = f_ptr_add(r_head, 2'd1);
  assign w_tail_1 = f_ptr_add(r_tail, 2'd1);

  assign w_valid_1 = (r_count != {CW{1'b0}});
  assign w_valid_2 = (r_count >= {{(CW-2){1'b0}}, 2'd2});

  // Clamp the decode request and never pop more than the queue holds.
  always_comb begin
    w_deq = (deq_count == 2'd3) ? 2'd2 : deq_count;
    if (w_valid_2) begin
      w_pop = w_deq;
    end else if (w_valid_1) begin
      w_pop = (w_deq != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      w_pop = 2'd0;
    end
    w_push_amt   = w_push ? {{(CW-2){1'b0}}, 2'd2} : {CW{1'b0}};
    w_count_next = r_count + w_push_amt - {{(CW-2){1'b0}}, w_pop};
  end

  // Fetch PC, in-flight tracking and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 16'h0000;
      r_head        <= {PW{1'b0}};
      r_tail        <= {PW{1'b0}};
      r_count       <= {CW{1'b0}};
    end else if (redirect_valid) begin
      r_pc          <= w_redir_pc;
      r_inflight    <= 1'b0;
      r_inflight_pc <= r_inflight_pc;
      r_head        <= {PW{1'b0}};
      r_tail        <= {PW{1'b0}};
      r_count       <= {CW{1'b0}};
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + 16'd4;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_pc          <= r_pc;
        r_inflight    <= 1'b0;
        r_inflight_pc <= r_inflight_pc;
      end
      if (w_push) begin
        r_tail <= f_ptr_add(r_tail, 2'd2);
      end else begin
        r_tail <= r_tail;
      end
      r_head  <= f_ptr_add(r_head, w_pop);
      r_count <= w_count_next;
    end
  end

  // Queue storage; slot 1 data lands ahead of slot 2 to keep program order.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_inst[r_tail]   <= im_inst_1;
      r_q_pc[r_tail]     <= r_inflight_pc;
      r_q_inst[w_tail_1] <= im_inst_2;
      r_q_pc[w_tail_1]   <= r_inflight_pc + 16'd2;
    end
  end

  assign im_addr_1   = r_pc;
  assign im_addr_2   = r_pc + 16'd2;
  assign out_valid_1 = w_valid_1;
  assign out_valid_2 = w_valid_2;
  assign out_inst_1  = w_valid_1 ? r_q_inst[r_head]   : 16'h0000;
  assign out_pc_1    = w_valid_1 ? r_q_pc[r_head]     : 16'h0000;
  assign out_inst_2  = w_valid_2 ? r_q_inst[w_head_1] : 16'h0000;
  assign out_pc_2    = w_valid_2 ? r_q_pc[w_head_1]   : 16'h0000;
  assign q_count     = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations on a depth-8 and a depth-4 unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Instruction memory contents: halfword i holds 16'h1000 + i.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- depth-8 unit ----------------
  logic        rst = 1'b1, redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [1:0]  deq_count = 2'd0;
  logic [15:0] im_addr_1, im_addr_2, im_inst_1, im_inst_2;
  logic        out_valid_1, out_valid_2;
  logic [15:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
  logic [3:0]  q_count;

  fetch_unit #(.QDEPTH(8), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr_1(im_addr_1), .im_addr_2(im_addr_2), .im_inst_1(im_inst_1), .im_inst_2(im_inst_2),
    .deq_count(deq_count), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_inst_1(out_inst_1), .out_inst_2(out_inst_2), .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
    .q_count(q_count)
  );

  always @(posedge clk) begin
    im_inst_1 <= mem_f(im_addr_1);
    im_inst_2 <= mem_f(im_addr_2);
  end

  // ---------------- depth-4 unit ----------------
  logic        rst4 = 1'b1, redir4 = 1'b0;
  logic [15:0] rpc4 = 16'h0000;
  logic [1:0]  deq4 = 2'd0;
  logic [15:0] a4_1, a4_2, i4_1, i4_2;
  logic        v4_1, v4_2;
  logic [15:0] oi4_1, oi4_2, op4_1, op4_2;
  logic [2:0]  q4;

  fetch_unit #(.QDEPTH(4), .RESET_PC(16'h0000)) u_dut4 (
    .clk(clk), .rst(rst4), .redirect_valid(redir4), .redirect_pc(rpc4),
    .im_addr_1(a4_1), .im_addr_2(a4_2), .im_inst_1(i4_1), .im_inst_2(i4_2),
    .deq_count(deq4), .out_valid_1(v4_1), .out_valid_2(v4_2),
    .out_inst_1(oi4_1), .out_inst_2(oi4_2), .out_pc_1(op4_1), .out_pc_2(op4_2),
    .q_count(q4)
  );

  always @(posedge clk) begin
    i4_1 <= mem_f(a4_1);
    i4_2 <= mem_f(a4_2);
  end

  // ---------------- reference model (depth 8) ----------------
  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_ipc;
  bit          m_infl;

  always @(posedge clk) begin
    int   dq;
    int   np;
    bit   iss;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_pc   = 16'h0000;
      m_infl = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc & 16'hFFFE;
      m_infl = 1'b0;
    end else begin
      dq  = (deq_count == 2'd3) ? 2 : int'(deq_count);
      np  = (dq < mq.size()) ? dq : mq.size();
      iss = (mq.size() + 2 * int'(m_infl)) <= 6;
      for (int k = 0; k < np; k++) void'(mq.pop_front());
      if (m_infl) begin
        e.pc = m_ipc;            e.inst = mem_f(e.pc); mq.push_back(e);
        e.pc = m_ipc + 16'd2;    e.inst = mem_f(e.pc); mq.push_back(e);
      end
      if (iss) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 16'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = mq.size();
      chk("im_addr_1", im_addr_1, m_pc);
      chk("im_addr_2", im_addr_2, m_pc + 16'd2);
      chk("q_count", q_count, sz);
      chk("q_bound", q_count <= 4'd8, 1);
      chk("out_valid_1", out_valid_1, sz >= 1);
      chk("out_valid_2", out_valid_2, sz >= 2);
      chk("out_inst_1", out_inst_1, (sz >= 1) ? mq[0].inst : 16'h0000);
      chk("out_pc_1",   out_pc_1,   (sz >= 1) ? mq[0].pc   : 16'h0000);
      chk("out_inst_2", out_inst_2, (sz >= 2) ? mq[1].inst : 16'h0000);
      chk("out_pc_2",   out_pc_2,   (sz >= 2) ? mq[1].pc   : 16'h0000);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    tick(2);
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_addr", im_addr_1, 16'h0000);
    chk("rst_q", q_count, 0);
    chk("rst_valid", out_valid_1, 0);

    // Fill with no decode consumption.
    tick(1);
    chk("fill_addr1", im_addr_1, 16'h0004);
    tick(4);
    chk("fill_q", q_count, 8);
    chk("fill_pc", im_addr_1, 16'h0010);
    chk("fill_inst1", out_inst_1, 16'h1000);
    chk("fill_pc2", out_pc_2, 16'h0002);
    chk("fill_inst2", out_inst_2, 16'h1001);
    tick(2);
    chk("full_hold_pc", im_addr_1, 16'h0010);
    chk("full_hold_q", q_count, 8);

    // Steady two-wide drain.
    deq_count = 2'd2;
    tick(1);
    chk("drain_pc1", out_pc_1, 16'h0004);
    chk("drain_inst1", out_inst_1, 16'h1002);
    tick(10);
    deq_count = 2'd0;
    tick(3);
    chk("refill_q", q_count, 8);

    // Redirect to an odd address with a fetch in flight.
    deq_count = 2'd1;
    tick(3);
    chk("pre_redir_q", q_count, 5);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    deq_count      = 2'd2;
    tick(1);
    redirect_valid = 1'b0;
    deq_count      = 2'd0;
    chk("redir_q", q_count, 0);
    chk("redir_addr", im_addr_1, 16'h0040);
    chk("redir_v0", out_valid_1, 0);
    tick(1);
    chk("redir_v1", out_valid_1, 0);
    chk("redir_addr1", im_addr_1, 16'h0044);
    tick(1);
    chk("redir_v2", out_valid_1, 1);
    chk("redir_pc1", out_pc_1, 16'h0040);
    chk("redir_inst1", out_inst_1, 16'h1020);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    chk("wrap_q", q_count, 2);
    chk("wrap_pc1", out_pc_1, 16'hFFFC);
    chk("wrap_pc2", out_pc_2, 16'hFFFE);
    chk("wrap_inst1", out_inst_1, 16'h8FFE);
    deq_count = 2'd2;
    tick(1);
    deq_count = 2'd0;
    chk("wrap_pc1b", out_pc_1, 16'h0000);
    chk("wrap_pc2b", out_pc_2, 16'h0002);
    chk("wrap_inst2b", out_inst_2, 16'h1001);

    // Reset mid-fill, with a simultaneous redirect that must lose.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    chk("midfill_q", q_count, 6);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    tick(1);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    chk("mrst_q", q_count, 0);
    chk("mrst_v", out_valid_1, 0);
    chk("mrst_addr", im_addr_1, 16'h0000);
    tick(1);
    chk("mrst_issue", im_addr_1, 16'h0004);

    // Depth-4 unit: reach a single-entry queue and over-request a pop.
    rst4 = 1'b0;
    tick(3);
    chk("d4_fill_q", q4, 4);
    tick(1);
    chk("d4_hold_q", q4, 4);
    deq4 = 2'd1;
    tick(1);
    chk("d4_q3", q4, 3);
    deq4 = 2'd2;
    tick(1);
    chk("d4_q1", q4, 1);
    chk("d4_v1", v4_1, 1);
    chk("d4_v2", v4_2, 0);
    chk("d4_pc1", op4_1, 16'h0006);
    chk("d4_inst1", oi4_1, 16'h1003);
    chk("d4_inst2", oi4_2, 16'h0000);
    tick(1);
    chk("d4_q0", q4, 0);
    chk("d4_v1_empty", v4_1, 0);
    chk("d4_pc_empty", op4_1, 16'h0000);
    tick(1);
    chk("d4_q2", q4, 2);
    chk("d4_pc8", op4_1, 16'h0008);
    chk("d4_inst8", oi4_1, 16'h1004);
    deq4 = 2'd3;
    tick(1);
    deq4 = 2'd0;
    chk("d4_deq3_q", q4, 2);
    chk("d4_deq3_pc", op4_1, 16'h000C);

    tick(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
